// File: rtl/spi_controller.sv
// SPI mode-0 bus master: turns one command into a 16-bit frame {rw, addr[6:0], data[7:0]}
// and returns the last eight CIPO bits of a read frame as rd_data.
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       busy,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  input  logic       cipo
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] HP_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  hp_cnt_q, hp_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        rw_q, rw_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        done_q, done_d;
  logic        sclk_q, sclk_d;
  logic        ncs_q, ncs_d;
  logic        copi_q, copi_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        cipo_meta_q, cipo_sync_q;
  logic        tick_s;

  assign tick_s = (hp_cnt_q == HP_LAST);

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    hp_cnt_d  = hp_cnt_q + 8'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    rw_d      = rw_q;
    rd_data_d = rd_data_q;
    copi_d    = copi_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hp_cnt_d = 8'd0;
        if (cmd_valid && ready_q) begin
          state_d   = ST_SETUP;
          shift_d   = {cmd_rw, cmd_addr, cmd_wdata};
          rw_d      = cmd_rw;
          copi_d    = cmd_rw;
          bit_cnt_d = 4'd0;
        end else begin
          copi_d = 1'b0;
        end
      end

      ST_SETUP: begin
        if (tick_s) begin
          state_d   = ST_HIGH;
          hp_cnt_d  = 8'd0;
          bit_cnt_d = 4'd0;
        end else begin
          state_d = ST_SETUP;
        end
      end

      ST_HIGH: begin
        if (tick_s) begin
          // Sample at the end of the high phase, then present the next bit on the falling edge.
          // The register rotates so every bit is consumed; only bit 14 of the old value is driven.
          state_d  = ST_LOW;
          hp_cnt_d = 8'd0;
          rx_d     = {rx_q[6:0], cipo_sync_q};
          shift_d  = {shift_q[14:0], shift_q[15]};
          if (bit_cnt_q == 4'd15) begin
            copi_d = 1'b0;
          end else begin
            copi_d = shift_q[14];
          end
        end else begin
          state_d = ST_HIGH;
        end
      end

      ST_LOW: begin
        if (tick_s) begin
          hp_cnt_d = 8'd0;
          if (bit_cnt_q == 4'd15) begin
            state_d = ST_GAP;
            done_d  = 1'b1;
            if (!rw_q) begin
              rd_data_d = rx_q;
            end else begin
              rd_data_d = rd_data_q;
            end
          end else begin
            state_d   = ST_HIGH;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          state_d = ST_LOW;
        end
      end

      ST_GAP: begin
        copi_d = 1'b0;
        if (hp_cnt_q == GAP_LAST) begin
          state_d  = ST_IDLE;
          hp_cnt_d = 8'd0;
        end else begin
          state_d = ST_GAP;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        hp_cnt_d = 8'd0;
        copi_d   = 1'b0;
      end
    endcase
  end

  // Pin-level outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    sclk_d  = (state_d == ST_HIGH);
    ncs_d   = !((state_d == ST_SETUP) || (state_d == ST_HIGH) || (state_d == ST_LOW));
    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
  end

  // State registers; reset forces the bus idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hp_cnt_q    <= 8'd0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 16'd0;
      rx_q        <= 8'd0;
      rw_q        <= 1'b0;
      rd_data_q   <= 8'd0;
      done_q      <= 1'b0;
      sclk_q      <= 1'b0;
      ncs_q       <= 1'b1;
      copi_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      cipo_meta_q <= 1'b0;
      cipo_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_cnt_q    <= hp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      sclk_q      <= sclk_d;
      ncs_q       <= ncs_d;
      copi_q      <= copi_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      cipo_meta_q <= cipo;
      cipo_sync_q <= cipo_meta_q;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign sclk      = sclk_q;
  assign ncs       = ncs_q;
  assign copi      = copi_q;

endmodule
